// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-requester arbiter owning one single-port synchronous RAM port
//
// Purpose: port 0 and port 1 each issue one read or write at a time over a
// req/ack handshake. The arbiter picks a winner, drives the registered RAM
// address/data/write-enable, captures the RAM read word and pulses ack for the
// winner. Each transaction takes three edges: IDLE -> ACCESS -> RESP -> IDLE.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   req0/we0/a0/d0    port 0 request, write select, address, write data
//   ack0/q0           port 0 one-cycle completion pulse, read data (held)
//   req1/we1/a1/d1    port 1 request, write select, address, write data
//   ack1/q1           port 1 one-cycle completion pulse, read data (held)
//   ram_a/ram_d/ram_we registered RAM address, write data, write enable
//   ram_q             RAM read data, valid one edge after the address is sampled
//   busy              high whenever the FSM is not in IDLE
//
// Build option: RAM_PORT_ARBITER_FIXED_PRI_EN selects fixed priority (port 0
// wins ties, port 1 can starve). Undefined: round-robin via the last pointer.

module ram_port_arbiter #(
    parameter int DW = 8,
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] a0,
    input  logic [DW-1:0] d0,
    output logic          ack0,
    output logic [DW-1:0] q0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] a1,
    input  logic [DW-1:0] d1,
    output logic          ack1,
    output logic [DW-1:0] q1,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_d,
    output logic          ram_we,
    input  logic [DW-1:0] ram_q,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state, state_nx;

    logic elig0, elig1, grant, gsel;
    logic win;     // port that owns the transaction in flight
    logic txn_we;  // write flag of the transaction in flight (ram_we is cleared at ACCESS)

    // A request seen during its own ack cycle is a leftover of the finished
    // transaction, not a new one.
    assign elig0 = req0 & ~ack0;
    assign elig1 = req1 & ~ack1;
    assign grant = elig0 | elig1;

`ifdef RAM_PORT_ARBITER_FIXED_PRI_EN
    assign gsel = ~elig0;
`else
    logic last;    // port granted most recently; the other port wins a tie

    assign gsel = (elig0 & elig1) ? ~last : elig1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
        end else if (state == IDLE && grant) begin
            last <= gsel;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant) state_nx = ACCESS;
            ACCESS:  state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_a  <= '0;
            ram_d  <= '0;
            ram_we <= 1'b0;
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            q0     <= '0;
            q1     <= '0;
            win    <= 1'b0;
            txn_we <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        ram_a  <= gsel ? a1 : a0;
                        ram_d  <= gsel ? d1 : d0;
                        ram_we <= gsel ? we1 : we0;
                        txn_we <= gsel ? we1 : we0;
                        win    <= gsel;
                    end else begin
                        ram_we <= 1'b0;
                    end
                end
                ACCESS: begin
                    ram_we <= 1'b0;
                end
                RESP: begin
                    if (!txn_we) begin
                        if (win) q1 <= ram_q;
                        else     q0 <= ram_q;
                    end
                    if (win) ack1 <= 1'b1;
                    else     ack0 <= 1'b1;
                end
                default: begin
                    ram_we <= 1'b0;
                end
            endcase
        end
    end

endmodule
